// File: rtl/dbus_bridge.sv
// Data-side bridge between the memory stage and a single-outstanding req/ack bus.
// A one-entry posted write buffer lets stores retire at zero wait; loads drain it first.
module dbus_bridge #(
  parameter bit POSTED_WR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] busaddr,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] wr_data,
  input  logic [2:0]  data_size,
  output logic        rw_wait,
  output logic [31:0] rd_data,
  output logic [31:0] m_addr,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_BUS,
    S_RD_DONE,
    S_WR_BUS,
    S_WB_BUS
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_wb_valid;
  logic [31:0] r_wb_addr;
  logic [3:0]  r_wb_be;
  logic [31:0] r_wb_data;

  logic        r_m_req;
  logic        r_m_we;
  logic [3:0]  r_m_be;
  logic [31:0] r_m_addr;
  logic [31:0] r_m_wdata;
  logic [31:0] r_rd_data;

  logic [3:0]  w_be;
  logic        w_ack;
  logic        w_rw_wait;
  logic        w_start_rd;
  logic        w_start_wr;
  logic        w_start_drain;
  logic        w_wb_load;
  logic        w_wb_clear;
  logic        w_rd_capture;

  // A stray ack with no request outstanding must not advance anything.
  assign w_ack = m_ack & r_m_req;

  always_comb begin
    case (data_size)
      3'b001:  w_be = 4'b0001 << busaddr[1:0];
      3'b010:  w_be = busaddr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next        = r_state;
    w_rw_wait     = 1'b0;
    w_start_rd    = 1'b0;
    w_start_wr    = 1'b0;
    w_start_drain = 1'b0;
    w_wb_load     = 1'b0;
    w_wb_clear    = 1'b0;
    w_rd_capture  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_wb_valid) begin
          w_rw_wait     = rd_req | wr_req;
          w_start_drain = 1'b1;
          w_next        = S_WB_BUS;
        end else if (rd_req) begin
          w_rw_wait  = 1'b1;
          w_start_rd = 1'b1;
          w_next     = S_RD_BUS;
        end else if (wr_req) begin
          if (POSTED_WR) begin
            w_wb_load = 1'b1;
          end else begin
            w_rw_wait  = 1'b1;
            w_start_wr = 1'b1;
            w_next     = S_WR_BUS;
          end
        end
      end
      S_RD_BUS: begin
        w_rw_wait = 1'b1;
        if (w_ack) begin
          // A load flushed while on the bus still completes, but its data is dropped.
          w_rd_capture = rd_req;
          w_next       = rd_req ? S_RD_DONE : S_IDLE;
        end
      end
      S_RD_DONE: w_next = S_IDLE;
      S_WR_BUS: begin
        w_rw_wait = ~w_ack;
        if (w_ack) w_next = S_IDLE;
      end
      S_WB_BUS: begin
        w_rw_wait = rd_req | wr_req;
        if (w_ack) begin
          w_wb_clear = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      r_state    <= S_IDLE;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_be    <= '0;
      r_wb_data  <= '0;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_be     <= '0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_rd_data  <= '0;
    end else begin
      r_state <= w_next;

      if (w_start_rd) begin
        r_m_req  <= 1'b1;
        r_m_we   <= 1'b0;
        r_m_be   <= 4'b1111;
        r_m_addr <= {busaddr[31:2], 2'b00};
      end else if (w_start_wr) begin
        r_m_req   <= 1'b1;
        r_m_we    <= 1'b1;
        r_m_be    <= w_be;
        r_m_addr  <= {busaddr[31:2], 2'b00};
        r_m_wdata <= wr_data;
      end else if (w_start_drain) begin
        r_m_req   <= 1'b1;
        r_m_we    <= 1'b1;
        r_m_be    <= r_wb_be;
        r_m_addr  <= r_wb_addr;
        r_m_wdata <= r_wb_data;
      end else if (w_ack) begin
        r_m_req <= 1'b0;
      end

      if (w_wb_load) begin
        r_wb_valid <= 1'b1;
        r_wb_addr  <= {busaddr[31:2], 2'b00};
        r_wb_be    <= w_be;
        r_wb_data  <= wr_data;
      end else if (w_wb_clear) begin
        r_wb_valid <= 1'b0;
      end

      if (w_rd_capture) r_rd_data <= m_rdata;
    end
  end

  assign rw_wait = w_rw_wait;
  assign rd_data = r_rd_data;
  assign m_req   = r_m_req;
  assign m_we    = r_m_we;
  assign m_be    = r_m_be;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;

endmodule

// File: tb/tb_dbus_bridge.sv
// Bench for dbus_bridge: a posted (unit 0) and a non-posted (unit 1) instance, each with
// a latency-programmable memory responder that checks bus transactions against a queue.
module tb_dbus_bridge;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  logic        clk;
  logic        rst;
  logic [31:0] busaddr   [2];
  logic        rd_req    [2];
  logic        wr_req    [2];
  logic [31:0] wr_data   [2];
  logic [2:0]  data_size [2];
  logic        rw_wait   [2];
  logic [31:0] rd_data   [2];
  logic [31:0] m_addr    [2];
  logic        m_req     [2];
  logic        m_we      [2];
  logic [3:0]  m_be      [2];
  logic [31:0] m_wdata   [2];
  logic        m_ack     [2];
  logic [31:0] m_rdata   [2];

  int          vectors = 0;
  int          miscompares = 0;
  int          lat     [2];
  logic [31:0] rd_word [2];
  bus_t        exp_q   [2][$];

  dbus_bridge #(.POSTED_WR(1'b1)) u_posted (
    .clk(clk), .rst(rst), .busaddr(busaddr[0]), .rd_req(rd_req[0]), .wr_req(wr_req[0]),
    .wr_data(wr_data[0]), .data_size(data_size[0]), .rw_wait(rw_wait[0]), .rd_data(rd_data[0]),
    .m_addr(m_addr[0]), .m_req(m_req[0]), .m_we(m_we[0]), .m_be(m_be[0]), .m_wdata(m_wdata[0]),
    .m_ack(m_ack[0]), .m_rdata(m_rdata[0])
  );

  dbus_bridge #(.POSTED_WR(1'b0)) u_direct (
    .clk(clk), .rst(rst), .busaddr(busaddr[1]), .rd_req(rd_req[1]), .wr_req(wr_req[1]),
    .wr_data(wr_data[1]), .data_size(data_size[1]), .rw_wait(rw_wait[1]), .rd_data(rd_data[1]),
    .m_addr(m_addr[1]), .m_req(m_req[1]), .m_we(m_we[1]), .m_be(m_be[1]), .m_wdata(m_wdata[1]),
    .m_ack(m_ack[1]), .m_rdata(m_rdata[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to have finished");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] be_model(input logic [2:0] size, input logic [31:0] a);
    if (size == 3'b001) begin
      case (a[1:0])
        2'd0:    return 4'b0001;
        2'd1:    return 4'b0010;
        2'd2:    return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (size == 3'b010) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // Memory responders: ack after lat[g] cycles of m_req, check stability and the expected queue.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    initial begin
      int   cnt;
      bus_t cur;
      bus_t now;
      bus_t want;
      cnt        = 0;
      m_ack[g]   = 1'b0;
      m_rdata[g] = '0;
      forever begin
        @(posedge clk);
        #1;
        if (rst) begin
          m_ack[g] = 1'b0;
          cnt      = 0;
        end else if (m_ack[g]) begin
          m_ack[g] = 1'b0;
          cnt      = 0;
        end else if (m_req[g]) begin
          now = {m_we[g], m_addr[g], m_be[g], m_wdata[g]};
          cnt++;
          if (cnt == 1) begin
            cur = now;
          end else begin
            vectors++;
            if (now !== cur) begin
              miscompares++;
              $display("FAIL bus_stable[%0d]: got %h, required %h", g, now, cur);
            end
          end
          if (cnt >= lat[g]) begin
            m_ack[g]   = 1'b1;
            m_rdata[g] = rd_word[g];
            vectors++;
            if (exp_q[g].size() == 0) begin
              miscompares++;
              $display("FAIL bus_unexpected[%0d]: got txn %h, required none", g, now);
            end else begin
              want = exp_q[g].pop_front();
              if (now.we !== want.we || now.addr !== want.addr || now.be !== want.be ||
                  (want.we && now.wdata !== want.wdata)) begin
                miscompares++;
                $display("FAIL bus_txn[%0d]: got we=%b addr=%h be=%b wdata=%h, required we=%b addr=%h be=%b wdata=%h",
                         g, now.we, now.addr, now.be, now.wdata, want.we, want.addr, want.be, want.wdata);
              end
            end
          end
        end
      end
    end
  end

  // Drive one request on unit u and hold it until rw_wait drops; check wait count and read data.
  task automatic access(input int u, input bit rd, input bit also_wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] data, input int exp_wait,
                        input logic [31:0] exp_rd, input string name);
    bus_t t;
    int   waits;
    t.we    = ~rd;
    t.addr  = {addr[31:2], 2'b00};
    t.be    = rd ? 4'b1111 : be_model(size, addr);
    t.wdata = data;
    exp_q[u].push_back(t);
    busaddr[u]   = addr;
    data_size[u] = size;
    wr_data[u]   = data;
    rd_req[u]    = rd;
    wr_req[u]    = ~rd | also_wr;
    waits = 0;
    forever begin
      @(negedge clk);
      if (rw_wait[u] === 1'b0) break;
      waits++;
      if (waits > 60) break;
    end
    vectors++;
    if (waits != exp_wait) begin
      miscompares++;
      $display("FAIL %s wait: got %0d cycles, required %0d", name, waits, exp_wait);
    end
    if (rd) begin
      vectors++;
      if (rd_data[u] !== exp_rd) begin
        miscompares++;
        $display("FAIL %s rd_data: got %h, required %h", name, rd_data[u], exp_rd);
      end
    end
    @(posedge clk);
    #1;
    rd_req[u] = 1'b0;
    wr_req[u] = 1'b0;
  endtask

  // Wait for all expected bus traffic of unit u to complete, bounded.
  task automatic drain_check(input int u, input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_q[u].size() == 0 && m_req[u] === 1'b0) break;
      n++;
      if (n > 40) break;
    end
    vectors++;
    if (exp_q[u].size() != 0) begin
      miscompares++;
      $display("FAIL %s drain: got %0d transactions outstanding, required 0", name, exp_q[u].size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    for (int u = 0; u < 2; u++) begin
      vectors += 4;
      if (m_req[u] !== 1'b0 || m_we[u] !== 1'b0 || m_be[u] !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_ctl[%0d]: got req=%b we=%b be=%b, required 0 0 0000", u, m_req[u], m_we[u], m_be[u]);
      end
      if (m_addr[u] !== 32'h0 || m_wdata[u] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_bus[%0d]: got addr=%h wdata=%h, required 0 0", u, m_addr[u], m_wdata[u]);
      end
      if (rd_data[u] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_rd_data[%0d]: got %h, required 0", u, rd_data[u]);
      end
      if (rw_wait[u] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_rw_wait[%0d]: got %b, required 0", u, rw_wait[u]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_load();
    lat[0] = 2;
    rd_word[0] = 32'hDEADBEEF;
    access(0, 1'b1, 1'b0, 32'h0000_1002, 3'b100, 32'h0, 3, 32'hDEADBEEF, "single_load");
    drain_check(0, "single_load");
  endtask

  task automatic test_posted_then_load();
    lat[0] = 2;
    rd_word[0] = 32'hA5A55A5A;
    access(0, 1'b0, 1'b0, 32'h0000_2001, 3'b001, 32'h0000AA00, 0, 32'h0, "posted_store");
    access(0, 1'b1, 1'b0, 32'h0000_3000, 3'b100, 32'h0, 6, 32'hA5A55A5A, "load_after_store");
    drain_check(0, "posted_then_load");
  endtask

  task automatic test_back_to_back();
    lat[0] = 3;
    access(0, 1'b0, 1'b0, 32'h0000_2104, 3'b100, 32'h11111111, 0, 32'h0, "b2b_store1");
    access(0, 1'b0, 1'b0, 32'h0000_2108, 3'b100, 32'h22222222, 4, 32'h0, "b2b_store2");
    drain_check(0, "back_to_back");
  endtask

  task automatic test_rd_wins();
    lat[0] = 2;
    rd_word[0] = 32'h0BADF00D;
    access(0, 1'b1, 1'b1, 32'h0000_3100, 3'b100, 32'h99999999, 3, 32'h0BADF00D, "rd_wins");
    drain_check(0, "rd_wins");
  endtask

  task automatic test_flush_abandon();
    bus_t t;
    int   n;
    lat[0] = 4;
    rd_word[0] = 32'h12345678;
    t = '{we: 1'b0, addr: 32'h0000_5004, be: 4'b1111, wdata: 32'h0};
    exp_q[0].push_back(t);
    busaddr[0]   = 32'h0000_5004;
    data_size[0] = 3'b100;
    rd_req[0]    = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rd_req[0] = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (m_ack[0] === 1'b1) break;
      vectors++;
      if (m_req[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL flush_m_req: got %b, required 1", m_req[0]);
      end
      n++;
      if (n > 20) break;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (rd_data[0] !== 32'h0BADF00D) begin
      miscompares++;
      $display("FAIL flush_rd_data: got %h, required %h", rd_data[0], 32'h0BADF00D);
    end
    lat[0] = 2;
    access(0, 1'b0, 1'b0, 32'h0000_6003, 3'b001, 32'hCC000000, 0, 32'h0, "flush_next_store");
    drain_check(0, "flush_abandon");
  endtask

  task automatic test_nonposted_be();
    logic [31:0] addr_tab [8] = '{32'h4002, 32'h4100, 32'h4101, 32'h4102,
                                  32'h4103, 32'h4200, 32'h4304, 32'h4401};
    logic [2:0]  size_tab [8] = '{3'b010, 3'b001, 3'b001, 3'b001,
                                  3'b001, 3'b010, 3'b100, 3'b111};
    lat[1] = 2;
    for (int i = 0; i < 8; i++) begin
      access(1, 1'b0, 1'b0, addr_tab[i], size_tab[i], 32'hBEEF0000 | i, 2, 32'h0, "nonposted_store");
    end
    rd_word[1] = 32'h600DCAFE;
    access(1, 1'b1, 1'b0, 32'h0000_4400, 3'b100, 32'h0, 3, 32'h600DCAFE, "nonposted_load");
    drain_check(1, "nonposted_be");
  endtask

  task automatic test_async_reset();
    lat[0] = 6;
    exp_q[0].push_back('{we: 1'b0, addr: 32'h0000_7000, be: 4'b1111, wdata: 32'h0});
    busaddr[0]   = 32'h0000_7000;
    data_size[0] = 3'b100;
    rd_req[0]    = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (m_req[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_pre_m_req: got %b, required 1", m_req[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    rd_req[0] = 1'b0;
    #0;
    vectors += 3;
    if (m_req[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_m_req: got %b, required 0", m_req[0]);
    end
    if (rd_data[0] !== 32'h0) begin
      miscompares++;
      $display("FAIL areset_rd_data: got %h, required 0", rd_data[0]);
    end
    if (rw_wait[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_rw_wait: got %b, required 0", rw_wait[0]);
    end
    exp_q[0].delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // A buffered store that has not reached the bus is lost by reset.
    lat[0] = 2;
    access(0, 1'b0, 1'b0, 32'h0000_8000, 3'b100, 32'h11112222, 0, 32'h0, "areset_store");
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (m_req[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_wb_m_req: got %b, required 0", m_req[0]);
    end
    exp_q[0].delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    rd_word[0] = 32'hCAFEF00D;
    access(0, 1'b1, 1'b0, 32'h0000_9000, 3'b100, 32'h0, 3, 32'hCAFEF00D, "areset_fresh_load");
    drain_check(0, "async_reset");
  endtask

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      busaddr[u]   = '0;
      rd_req[u]    = 1'b0;
      wr_req[u]    = 1'b0;
      wr_data[u]   = '0;
      data_size[u] = 3'b100;
      lat[u]       = 2;
      rd_word[u]   = '0;
    end
    test_reset();
    test_single_load();
    test_posted_then_load();
    test_back_to_back();
    test_rd_wins();
    test_flush_abandon();
    test_nonposted_be();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dbus_bridge.md
Name: dbus_bridge

Overview:
- Data-side bus bridge directly downstream of the pipeline memory stage.
- Consumes the stage's busaddr/rd_req/wr_req/wr_data/data_size requests and returns rw_wait/rd_data.
- Drives a single-outstanding req/ack memory bus.
- Contains a one-entry posted write buffer so stores normally complete with zero wait. Loads are ordered behind any pending store.

Parameters:
- POSTED_WR, 1: 1 = stores enter the write buffer and retire immediately; 0 = stores hold rw_wait until m_ack.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- busaddr  in  32  byte address from memory stage
- rd_req  in  1  read request, level, held while rw_wait
- wr_req  in  1  write request, level, held while rw_wait
- wr_data  in  32  write data, already lane-aligned by the stage
- data_size  in  3  001 byte, 010 half, 100 word
- rw_wait  out  1  combinational; 1 = request not done this cycle
- rd_data  out  32  read word; valid only in the cycle rd_req=1 and rw_wait=0
- m_addr  out  32  word address, with [1:0] forced to 00
- m_req  out  1  memory request
- m_we  out  1  1 = write
- m_be  out  4  byte enables
- m_wdata  out  32  write data
- m_ack  in  1  one-cycle completion pulse
- m_rdata  in  32  read data, valid with m_ack

Behaviour:
- Reset, asynchronous, any state:
  - state=IDLE, write buffer empty (wb_valid=0), m_req=0, m_we=0, m_be=0, m_addr=0, m_wdata=0, rd_data=0.
  - rw_wait follows the combinational rules below: 0 when no request is present.
- Byte-enable rule:
  - 001 → 4'b0001<<busaddr[1:0]
  - 010 → busaddr[1] ? 1100 : 0011
  - 100 or any other code → 1111
- Bus rules:
  - Once m_req rises, m_addr, m_we, m_be and m_wdata stay stable until the cycle m_ack=1.
  - m_req drops the cycle after m_ack.
  - At most one transaction is outstanding. m_ack while m_req=0 is ignored.
- Main FSM states: IDLE, RD_BUS, RD_DONE, WR_BUS. The write buffer drains through WB_BUS.
- IDLE:
  - rd_req with wb_valid=1: rw_wait=1; the buffer drains first.
  - rd_req with wb_valid=0: rw_wait=1; latch the word address; go to RD_BUS with m_req=1, m_we=0, m_be=1111.
  - wr_req with POSTED_WR=1 and wb_valid=0: rw_wait=0; capture {addr, be, data} into the buffer at the clock edge; wb_valid=1.
  - wr_req with POSTED_WR=1 and wb_valid=1: rw_wait=1 until the drain completes. The store is accepted in the first IDLE cycle with wb_valid=0.
  - wr_req with POSTED_WR=0: rw_wait=1; go to WR_BUS.
  - rd_req and wr_req both high: rd_req wins; wr_req is ignored.
  - No request and wb_valid=1: start the drain (WB_BUS) with m_req=1, m_we=1, using the buffered fields.
- RD_BUS:
  - rw_wait=1.
  - On m_ack: rd_data<=m_rdata; go to RD_DONE.
- RD_DONE:
  - rw_wait=0; rd_data holds the captured word.
  - Next state is IDLE.
  - A new request in this cycle is not started; it begins from IDLE the next cycle.
  - Minimum load latency: request cycle + 1 + memory latency.
- WR_BUS (POSTED_WR=0):
  - rw_wait=1 until the cycle m_ack=1. In that cycle rw_wait=0 and the next state is IDLE.
- WB_BUS:
  - rw_wait=1 for any incoming request.
  - On m_ack: wb_valid<=0; go to IDLE.
- Abandon: if rd_req drops while in RD_BUS (pipeline flush), the bus transaction still completes on m_ack. The data is discarded; the next state is IDLE, not RD_DONE.
- Address compare: the drain always precedes the load. No forwarding from the buffer.
- rd_data is a registered word, unaligned. Lane selection, sign extension and byte rotation are done by the stage.
- Reset mid-transaction: the bridge drops m_req immediately. The memory side is also reset by rst; the buffered store is lost.

Test Plan:
- Single load:
  - Stimulus: rd_req=1, busaddr=0x1002, m_ack two cycles after m_req, m_rdata=0xDEADBEEF.
  - Required: m_addr=0x1000, m_be=1111, rw_wait high 3 cycles. rw_wait=0 with rd_data=0xDEADBEEF in RD_DONE, then IDLE.
- Posted store then load:
  - Stimulus: wr_req with busaddr=0x2001, data_size=001, wr_data=0x0000AA00; next cycle rd_req to 0x3000.
  - Required: store sees rw_wait=0. Bus shows the write (m_be=0010, m_addr=0x2000) acked before the read's m_req rises. The load sees rw_wait until its own m_ack.
- Back-to-back stores:
  - Stimulus: two consecutive wr_req, m_ack latency 3.
  - Required: the first store retires at 0 wait. The second has rw_wait=1 until the drain m_ack, then is accepted the next IDLE cycle; exactly two bus writes occur, in order.
- Flush abandon:
  - Stimulus: rd_req rises, then drops one cycle into RD_BUS.
  - Required: m_req stays high until m_ack; rd_data is unchanged from its prior value; state returns to IDLE; a following wr_req is accepted the cycle after.
- POSTED_WR=0 and half-word enables:
  - Stimulus: wr_req to 0x4002 with data_size=010.
  - Required: m_be=1100; rw_wait=1 until the m_ack cycle, then 0.
- Asynchronous reset:
  - Stimulus: rst pulse mid-RD_BUS, not aligned to clk.
  - Required: m_req=0 and rd_data=0 immediately; wb_valid=0; a fresh load after reset works normally.
